if_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Generates the sequential PC and issues requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions with their pc/pc4 in a small FIFO and presents them to decode as an id_stage_in_t under a valid/ready handshake.
- A redirect from the branch/jump resolution point flushes in-flight and buffered fetches and restarts at the target.

---
 rtl/id_stage_pkg.sv | 11 +
 rtl/if_stage_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/if_stage.sv | 146 ++++++++++++++
 tb/tb_if_stage.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// Decode-stage shared types.
// Holds the bundle handed from fetch to decode.
package id_stage_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } id_stage_in_t;

endpackage

// File: rtl/if_stage_pkg.sv
// Fetch-stage shared types and sizing helpers.
// Counters hold 0..DEPTH inclusive, hence the extra bit.
package if_stage_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } fetch_entry_t;

  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned DEF_CNT_W = $clog2(DEF_DEPTH) + 1;

  function automatic int unsigned cnt_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for fetch data and pc tags.
// DEPTH is a power of two so pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign count = cnt_q;
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_q];

  // Next-state: flush wins, otherwise push/pop may both happen.
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + (PW+1)'(do_push)
                    - (PW+1)'(do_pop);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: sequential PC, credit-limited imem requests,
// buffered responses to decode, redirect flushes stale fetches.
module if_stage
  import if_stage_pkg::*;
  import id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  input  logic         redirect_en,
  input  logic [31:0]  redirect_pc,
  output logic         if_valid,
  input  logic         id_ready,
  output id_stage_in_t if_out
);

  localparam int unsigned CW = cnt_w(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam int unsigned EW = $bits(fetch_entry_t);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] inst_cnt, tag_cnt, occ;
  logic          accept, keep, inst_pop;
  logic          inst_empty, inst_full;
  logic          tag_empty, tag_full;
  logic [31:0]   tag_pc;
  fetch_entry_t  push_ent, head_ent;

  // Request issue, response acceptance and decode-side handshake.
  always_comb begin
    occ            = out_q + inst_cnt;
    imem_req_valid = !rst && !redirect_en
                     && (occ < DEPTH_C);
    imem_addr      = rst ? RESET_PC : pc_q;
    accept         = imem_req_valid && imem_req_ready;
    keep           = imem_rsp_valid && !redirect_en
                     && (drop_q == '0);
    if_valid       = !rst && !inst_empty && !redirect_en;
    inst_pop       = if_valid && id_ready;
    push_ent.inst  = imem_rsp_data;
    push_ent.pc    = tag_pc;
    push_ent.pc4   = tag_pc + 32'd4;
    if_out         = '0;
    if (!rst && !inst_empty) begin
      if_out.inst = head_ent.inst;
      if_out.pc   = head_ent.pc;
      if_out.pc4  = head_ent.pc4;
    end
  end

  // Next pc, outstanding count and stale-response drop count.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    out_d  = out_q + CW'(accept)
                   - CW'(imem_rsp_valid);
    if (accept) begin
      pc_d = pc_q + 32'd4;
    end
    if (redirect_en) begin
      pc_d   = redirect_pc & ~32'h3;
      drop_d = out_q - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && drop_q != '0) begin
      drop_d = drop_q - CW'(1);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (keep),
    .flush (redirect_en),
    .wdata (pc_q),
    .rdata (tag_pc),
    .count (tag_cnt),
    .full  (tag_full),
    .empty (tag_empty)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .pop   (inst_pop),
    .flush (redirect_en),
    .wdata (push_ent),
    .rdata (head_ent),
    .count (inst_cnt),
    .full  (inst_full),
    .empty (inst_empty)
  );

  a_credit: assert property (
    @(posedge clk) disable iff (rst)
    occ <= DEPTH_C);

  a_tags: assert property (
    @(posedge clk) disable iff (rst)
    tag_cnt == out_q - drop_q);

  a_tag_pop: assert property (
    @(posedge clk) disable iff (rst)
    keep |-> !tag_empty);

  a_tag_push: assert property (
    @(posedge clk) disable iff (rst)
    accept |-> !tag_full);

  a_buf_push: assert property (
    @(posedge clk) disable iff (rst)
    keep |-> (!inst_full || redirect_en));

  a_rsp_owed: assert property (
    @(posedge clk) disable iff (rst)
    imem_rsp_valid |-> out_q != '0);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order imem model.
// Redirect scenarios are table-driven; the rest are short sequences.
module tb_if_stage;
  import id_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic         redirect_en;
  logic [31:0]  redirect_pc;
  logic         if_valid;
  logic         id_ready;
  id_stage_in_t if_out;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .if_out         (if_out)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    int          lat;
    int          warm;
    logic [31:0] rpc;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc4;
  } rvec_t;

  mreq_t        mq[$];
  id_stage_in_t got[$];
  rvec_t        vt[5];
  int           cyc, lat, checks, errors, n_acc;
  bit           nop_mode;
  logic         s_rv, s_iv, s_acc;
  logic [31:0]  s_addr;
  id_stage_in_t s_out;

  function automatic logic [31:0] mdata(logic [31:0] a);
    return nop_mode ? 32'h0000_0013 : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic chk(string name, logic [95:0] act,
                     logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample outputs at negedge, advance, then update the memory model.
  task automatic tick();
    logic rv_was, rst_was;
    @(negedge clk);
    s_rv    = imem_req_valid;
    s_addr  = imem_addr;
    s_iv    = if_valid;
    s_out   = if_out;
    s_acc   = imem_req_valid && imem_req_ready;
    rv_was  = imem_rsp_valid;
    rst_was = rst;
    if (s_iv && id_ready) got.push_back(s_out);
    @(posedge clk);
    #1;
    cyc++;
    if (rst_was) begin
      mq.delete();
    end else begin
      if (rv_was && mq.size() > 0) void'(mq.pop_front());
      if (s_acc) mq.push_back('{s_addr, cyc + lat - 1});
    end
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    got.delete();
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_en    = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    lat            = 1;
    nop_mode       = 1'b1;
    cyc            = 0;
    checks         = 0;
    errors         = 0;

    vt[0] = '{1, 4, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    vt[1] = '{2, 6, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    vt[2] = '{1, 5, 32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
    vt[3] = '{2, 6, 32'h0000_03FF, 32'h0000_03FC, 32'h0000_0400};
    vt[4] = '{1, 3, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};

    // Reset state and zero-wait streaming
    do_reset();
    chk("rst req_valid", 96'(s_rv), 96'(0));
    chk("rst if_valid", 96'(s_iv), 96'(0));
    chk("rst if_out", 96'(s_out), 96'(0));
    chk("rst addr", 96'(s_addr), 96'(0));
    rst = 1'b0;
    tick();
    chk("t1 first req", 96'(s_rv), 96'(1));
    chk("t1 first addr", 96'(s_addr), 96'(0));
    tick();
    chk("t1 n+1 if_valid", 96'(s_iv), 96'(0));
    tick();
    chk("t1 n+2 if_valid", 96'(s_iv), 96'(1));
    chk("t1 head", 96'(s_out), {32'h13, 32'h0, 32'h4});
    repeat (12) tick();
    chk("t1 count", 96'(got.size() >= 6), 96'(1));
    for (int k = 0; k < 6 && k < got.size(); k++)
      chk($sformatf("t1 e%0d", k), 96'(got[k]),
          {32'h13, 32'(4 * k), 32'(4 * k + 4)});

    // Decode stall: credits run out, head holds
    id_ready = 1'b0;
    do_reset();
    rst   = 1'b0;
    n_acc = 0;
    repeat (5) begin
      tick();
      if (s_acc) n_acc++;
    end
    chk("t2 accepts", 96'(n_acc), 96'(2));
    chk("t2 req stopped", 96'(s_rv), 96'(0));
    chk("t2 if_valid", 96'(s_iv), 96'(1));
    chk("t2 head pc", 96'(s_out.pc), 96'(0));
    id_ready = 1'b1;
    repeat (12) tick();
    chk("t2 count", 96'(got.size() >= 5), 96'(1));
    for (int k = 0; k < 5 && k < got.size(); k++)
      chk($sformatf("t2 pc%0d", k), 96'(got[k].pc),
          96'(32'(4 * k)));

    // Memory not ready: address holds until accepted
    imem_req_ready = 1'b0;
    do_reset();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t3 stall req%0d", k), 96'(s_rv), 96'(1));
      chk($sformatf("t3 stall addr%0d", k), 96'(s_addr), 96'(0));
    end
    imem_req_ready = 1'b1;
    tick();
    chk("t3 accept addr", 96'(s_addr), 96'(0));
    tick();
    chk("t3 next addr", 96'(s_addr), 96'(4));

    // Redirect scenarios
    nop_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lat = vt[i].lat;
      do_reset();
      rst = 1'b0;
      repeat (vt[i].warm) tick();
      redirect_en = 1'b1;
      redirect_pc = vt[i].rpc;
      tick();
      chk($sformatf("v%0d redir req", i), 96'(s_rv), 96'(0));
      chk($sformatf("v%0d redir valid", i), 96'(s_iv), 96'(0));
      redirect_en = 1'b0;
      got.delete();
      tick();
      chk($sformatf("v%0d restart req", i), 96'(s_rv), 96'(1));
      chk($sformatf("v%0d restart addr", i), 96'(s_addr),
          96'(vt[i].exp_pc));
      repeat (12) tick();
      chk($sformatf("v%0d count", i), 96'(got.size() >= 2),
          96'(1));
      if (got.size() >= 2) begin
        chk($sformatf("v%0d first", i), 96'(got[0]),
            {mdata(vt[i].exp_pc), vt[i].exp_pc, vt[i].exp_pc4});
        chk($sformatf("v%0d second pc", i), 96'(got[1].pc),
            96'(vt[i].exp_pc4));
      end
    end

    // Back-to-back redirects: the last target wins
    lat = 2;
    do_reset();
    rst = 1'b0;
    repeat (5) tick();
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0400;
    tick();
    redirect_pc = 32'h0000_0800;
    tick();
    redirect_en = 1'b0;
    got.delete();
    repeat (12) tick();
    chk("b2b count", 96'(got.size() >= 2), 96'(1));
    if (got.size() >= 2) begin
      chk("b2b first", 96'(got[0]),
          {mdata(32'h800), 32'h800, 32'h804});
      chk("b2b second pc", 96'(got[1].pc), 96'(32'h804));
    end

    // Reset in the middle of a stream
    rst = 1'b1;
    tick();
    chk("midrst if_valid", 96'(s_iv), 96'(0));
    rst = 1'b0;
    tick();
    chk("postrst if_valid", 96'(s_iv), 96'(0));
    chk("postrst addr", 96'(s_addr), 96'(0));
    chk("postrst req", 96'(s_rv), 96'(1));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
